// File: rtl/best_arr_sender.sv
// Streams the best-match array (index phase, then distance phase) into an output FIFO
// in blocked px/x/y/xi order, one read per tuple and one or two pushes per tuple.
module best_arr_sender #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int DIST_WIDTH = 22,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_best_arr,
  output logic                  send_done,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  input  logic [DIST_WIDTH-1:0] rd_dist,
  output logic                  out_fifo_wenq,
  output logic [DATA_WIDTH-1:0] out_fifo_wdata,
  input  logic                  out_fifo_wfull_n
);

  localparam int HALF = ROW_SIZE / 2;
  localparam int NX   = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int XW   = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int BW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

  typedef enum logic [2:0] {IDLE, RD, CAP, PUSH_LO, PUSH_HI, DONE} state_t;

  state_t state, next_state;

  logic                  px;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [BW-1:0]         xi;
  logic                  phase_dist;
  logic [IDX_WIDTH-1:0]  hold_idx;
  logic [DIST_WIDTH-1:0] hold_dist;
  logic [DIST_WIDTH-1:0] dist_hi;

  logic xi_wrap, y_wrap, x_wrap, last_tuple, tuple_end;

  // xi wraps early on the last x block so out-of-row columns are never visited
  always_comb begin
    xi_wrap    = (int'(xi) == BLOCKING - 1) ||
                 (int'(x) * BLOCKING + int'(xi) + 1 >= HALF);
    y_wrap     = (int'(y) == COL_SIZE - 1);
    x_wrap     = (int'(x) == NX - 1);
    last_tuple = xi_wrap && y_wrap && x_wrap && px;
    rd_addr    = ADDR_WIDTH'(int'(px) * HALF + int'(y) * ROW_SIZE +
                             int'(x) * BLOCKING + int'(xi));
    dist_hi    = hold_dist >> DATA_WIDTH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state     = state;
    send_done      = 1'b0;
    busy           = (state != IDLE);
    rd_en          = 1'b0;
    out_fifo_wenq  = 1'b0;
    out_fifo_wdata = '0;
    tuple_end      = 1'b0;
    case (state)
      IDLE: if (send_best_arr) next_state = RD;
      RD: begin
        rd_en      = 1'b1;
        next_state = CAP;
      end
      CAP: next_state = PUSH_LO;
      PUSH_LO: begin
        out_fifo_wenq  = out_fifo_wfull_n;
        out_fifo_wdata = phase_dist ? DATA_WIDTH'(hold_dist) : DATA_WIDTH'(hold_idx);
        if (out_fifo_wfull_n) begin
          next_state = phase_dist ? PUSH_HI : RD;
          tuple_end  = !phase_dist;
        end
      end
      PUSH_HI: begin
        out_fifo_wenq  = out_fifo_wfull_n;
        out_fifo_wdata = DATA_WIDTH'(dist_hi);
        if (out_fifo_wfull_n) begin
          next_state = last_tuple ? DONE : RD;
          tuple_end  = 1'b1;
        end
      end
      DONE: begin
        send_done  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Odometer wraps back to all-zero on the final tuple, which also flips the phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px         <= 1'b0;
      x          <= '0;
      y          <= '0;
      xi         <= '0;
      phase_dist <= 1'b0;
      hold_idx   <= '0;
      hold_dist  <= '0;
    end else begin
      if (state == CAP) begin
        hold_idx  <= rd_idx;
        hold_dist <= rd_dist;
      end
      if (tuple_end) begin
        if (xi_wrap) begin
          xi <= '0;
          if (y_wrap) begin
            y <= '0;
            if (x_wrap) begin
              x  <= '0;
              px <= ~px;
              if (px) phase_dist <= ~phase_dist;
            end else begin
              x <= x + XW'(1);
            end
          end else begin
            y <= y + YW'(1);
          end
        end else begin
          xi <= xi + BW'(1);
        end
      end
    end
  end

endmodule

// File: doc/best_arr_sender.md
BEST_ARR_SENDER -- requirements
Module: best_arr_sender

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, FIFO word width.
REQ-002 SHALL have parameter IDX_WIDTH, default 9, best-match patch index width.
REQ-003 SHALL have parameter DIST_WIDTH, default 22, best distance width; legal range is at most 2*DATA_WIDTH.
REQ-004 SHALL have parameters ROW_SIZE = 26, COL_SIZE = 19, BLOCKING = 4, NUM_QUERYS = ROW_SIZE*COL_SIZE, ADDR_WIDTH = $clog2(NUM_QUERYS).
REQ-005 SHALL use a single clock and an asynchronous, active-high reset.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk, in, 1, sole clock
- rst, in, 1, asynchronous active-high reset
- send_best_arr, in, 1, one-cycle start pulse
- send_done, out, 1, one-cycle completion pulse
- busy, out, 1, high from the cycle after start until the cycle send_done is high
- rd_en, out, 1, best-array read strobe
- rd_addr, out, ADDR_WIDTH, query address
- rd_idx, in, IDX_WIDTH, index data, valid 1 cycle after rd_en
- rd_dist, in, DIST_WIDTH, distance data, valid 1 cycle after rd_en
- out_fifo_wenq, out, 1, output-FIFO enqueue
- out_fifo_wdata, out, DATA_WIDTH, enqueue data
- out_fifo_wfull_n, in, 1, output FIFO not full

Function
REQ-007 SHALL implement these states: IDLE, RD, CAP, PUSH_LO, PUSH_HI, DONE.
REQ-008 SHALL move IDLE->RD on send_best_arr=1; a send_best_arr pulse in any state other than IDLE SHALL be ignored.
REQ-009 SHALL, in RD, drive rd_en=1 and rd_addr=current address, then go to CAP.
REQ-010 SHALL, in CAP, capture rd_idx and rd_dist into a hold register, then go to PUSH_LO.
REQ-011 SHALL drive out_fifo_wenq = (state is PUSH_LO or PUSH_HI) AND out_fifo_wfull_n, combinationally; a word is transferred only in a cycle with wenq=1.
REQ-012 SHALL hold state and out_fifo_wdata stable while out_fifo_wfull_n=0, with no limit on stall length.
REQ-013 SHALL run two phases: IDX phase, then DIST phase.
- IDX phase: PUSH_LO sends the index zero-extended to DATA_WIDTH.
- DIST phase: PUSH_LO sends dist[DATA_WIDTH-1:0], then PUSH_HI sends the upper bits zero-extended.
REQ-014 SHALL visit addresses in loop order px(0..1), x(0..NX-1), y(0..COL_SIZE-1), xi(0..BLOCKING-1), where NX = ceil((ROW_SIZE/2)/BLOCKING).
- addr = px*ROW_SIZE/2 + y*ROW_SIZE + x*BLOCKING + xi
- tuples with x*BLOCKING+xi >= ROW_SIZE/2 SHALL be skipped with no read and no push.
REQ-015 SHALL advance to the next tuple's RD after the final push of each tuple.
REQ-016 SHALL, after the last IDX tuple, restart the loop counters and begin the DIST phase.
REQ-017 SHALL, after the last DIST tuple, enter DONE, assert send_done for exactly 1 cycle, then return to IDLE.
REQ-018 Latency: with start sampled in cycle T and wfull_n held at 1, rd_en SHALL be high at T+1 and the first wenq SHALL occur at T+3.
REQ-019 SHALL make exactly NUM_QUERYS index writes followed by 2*NUM_QUERYS distance writes per start; the defaults give 494 + 988 = 1482.
REQ-020 rd_en SHALL be high only in RD; out_fifo_wdata is don't-care whenever wenq=0.

Reset
REQ-021 SHALL, on rst asserted at any time, force state IDLE, zero all counters and the hold register, and drive send_done=0, busy=0, rd_en=0, rd_addr=0, out_fifo_wenq=0, out_fifo_wdata=0.
REQ-022 SHALL abandon a transfer interrupted by reset without asserting send_done; a new send_best_arr after reset release SHALL restart from addr 0 in the IDX phase.

Verification
REQ-023 Defaults, rd data = f(addr), wfull_n=1 throughout:
- first four rd_addr values are 0, 1, 2, 3, then 26.
- the last addr of px=0 is 480, the first of px=1 is 13, and the last overall is 493.
- 1482 writes occur, then one send_done pulse.
REQ-024 dist[addr] = 0x2ABCDE for all addresses -> every DIST pair is 0x4DE then 0x557.
REQ-025 wfull_n=0 for 50 cycles in the middle of PUSH_HI -> wenq=0, wdata is unchanged, and no word is lost or duplicated.
REQ-026 Random wfull_n (50% duty) -> the received stream equals the golden order, and wenq is never high while wfull_n=0.
REQ-027 rst pulsed at write 700, then a new start -> no send_done before the restart, and the new stream begins at addr 0 in the IDX phase.
REQ-028 send_best_arr re-pulsed while busy -> ignored, and exactly 1482 writes occur.
